// File: rtl/hexload_pkg.sv
// Shared types and helpers for the ASCII-hex program loader: FSM state encoding,
// framing characters and the hex digit decoder.
package hexload_pkg;

  typedef enum logic [1:0] {
    StAcc,
    StWr,
    StFull,
    StDone
  } state_e;

  localparam logic [7:0] AsciiSpace = 8'h20;
  localparam logic [7:0] AsciiCr    = 8'h0D;
  localparam logic [7:0] AsciiLf    = 8'h0A;
  localparam logic [7:0] AsciiUnder = 8'h5F;
  localparam logic [7:0] AsciiTerm  = 8'h2E;

  // Returns {is_digit, nibble}; letters are accepted in either case.
  function automatic logic [4:0] ascii_to_nibble(input logic [7:0] c);
    logic [4:0] r;
    r = '0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      r = {1'b1, c[3:0] + 4'd9};
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_hex_loader_if.sv
// Byte-stream, echo and memory-write signals of the hex loader. The loader takes the
// slave view; the UART/memory side (or a bench) takes the master view.
interface uart_hex_loader_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              tx_ready;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport slave (
    input  rx_valid, rx_data, tx_ready,
    output rx_ready, tx_valid, tx_data, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output rx_valid, rx_data, tx_ready,
    input  rx_ready, tx_valid, tx_data, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/hex_classify.sv
// Combinational byte classifier: hex digit (with value), separator, terminator or bad.
module hex_classify
  import hexload_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic       is_digit_o,
  output logic       is_sep_o,
  output logic       is_term_o,
  output logic       is_bad_o,
  output logic [3:0] nib_o
);

  always_comb begin
    {is_digit_o, nib_o} = ascii_to_nibble(byte_i);
    is_sep_o  = (byte_i == AsciiSpace) || (byte_i == AsciiCr) ||
                (byte_i == AsciiLf) || (byte_i == AsciiUnder);
    is_term_o = (byte_i == AsciiTerm);
    is_bad_o  = !(is_digit_o || is_sep_o || is_term_o);
  end

endmodule

// File: rtl/uart_hex_loader.sv
// ASCII-hex program loader: packs hex digits into DATA_W-bit words and writes them
// sequentially to instruction memory. Define HEXLOAD_ECHO_EN to echo accepted bytes.
module uart_hex_loader
  import hexload_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                arm_i,
  uart_hex_loader_if.slave    bus_io,
  output logic [ADDR_W:0]     word_count_o,
  output logic                load_done_o,
  output logic                err_bad_char_o,
  output logic                err_overflow_o
);

  localparam int unsigned DIGITS = DATA_W / 4;
  localparam int unsigned CNT_W  = $clog2(DIGITS + 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   wc_q, wc_d;
  logic              term_q, term_d;
  logic              done_q, done_d;
  logic              bad_q, bad_d;
  logic              ovf_q, ovf_d;

  logic       is_digit, is_sep, is_term, is_bad;
  logic [3:0] nib;
  logic       xfer;
  logic       echo_ok;

  hex_classify u_classify (
    .byte_i     (bus_io.rx_data),
    .is_digit_o (is_digit),
    .is_sep_o   (is_sep),
    .is_term_o  (is_term),
    .is_bad_o   (is_bad),
    .nib_o      (nib)
  );

`ifdef HEXLOAD_ECHO_EN
  assign echo_ok = bus_io.tx_ready;
`else
  assign echo_ok = 1'b1;
`endif

  assign xfer = bus_io.rx_valid && bus_io.rx_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StAcc;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (arm_i) begin
      state_d = StAcc;
    end else begin
      unique case (state_q)
        StAcc: begin
          if (xfer) begin
            if (is_digit && cnt_q == CNT_W'(DIGITS - 1)) begin
              state_d = StWr;
            end else if (is_sep && cnt_q != '0) begin
              state_d = StWr;
            end else if (is_term) begin
              state_d = (cnt_q != '0) ? StWr : StDone;
            end
          end
        end
        StWr: begin
          if (term_q) begin
            state_d = StDone;
          end else if (wc_q + 1'b1 == (ADDR_W + 1)'(DEPTH)) begin
            state_d = StFull;
          end else begin
            state_d = StAcc;
          end
        end
        StFull: begin
          if (xfer && is_term) begin
            state_d = StDone;
          end
        end
        StDone: state_d = StDone;
        default: state_d = StAcc;
      endcase
    end
  end

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    ptr_d  = ptr_q;
    wc_d   = wc_q;
    term_d = term_q;
    done_d = done_q;
    bad_d  = bad_q;
    ovf_d  = ovf_q;
    if (arm_i) begin
      acc_d  = '0;
      cnt_d  = '0;
      ptr_d  = '0;
      wc_d   = '0;
      term_d = 1'b0;
      done_d = 1'b0;
      bad_d  = 1'b0;
      ovf_d  = 1'b0;
    end else begin
      unique case (state_q)
        StAcc: begin
          if (xfer) begin
            if (is_digit) begin
              acc_d = {acc_q[DATA_W-5:0], nib};
              cnt_d = cnt_q + CNT_W'(1);
            end else if (is_term) begin
              term_d = (cnt_q != '0);
              done_d = (cnt_q == '0);
            end else if (is_bad) begin
              // Drop the partial word so later digits restart right-justified.
              acc_d = '0;
              cnt_d = '0;
              bad_d = 1'b1;
            end
          end
        end
        StWr: begin
          acc_d  = '0;
          cnt_d  = '0;
          term_d = 1'b0;
          if (term_q) done_d = 1'b1;
          if (ptr_q != ADDR_W'(DEPTH - 1)) ptr_d = ptr_q + 1'b1;
          if (wc_q != (ADDR_W + 1)'(DEPTH)) wc_d = wc_q + 1'b1;
        end
        StFull: begin
          if (xfer) begin
            if (is_digit) ovf_d = 1'b1;
            if (is_bad) bad_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      ptr_q  <= '0;
      wc_q   <= '0;
      term_q <= 1'b0;
      done_q <= 1'b0;
      bad_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      ptr_q  <= ptr_d;
      wc_q   <= wc_d;
      term_q <= term_d;
      done_q <= done_d;
      bad_q  <= bad_d;
      ovf_q  <= ovf_d;
    end
  end

`ifdef HEXLOAD_ECHO_EN
  logic       txv_q, txv_d;
  logic [7:0] txd_q, txd_d;

  always_comb begin
    txv_d = !arm_i && xfer && (state_q == StAcc || state_q == StFull);
    txd_d = txv_d ? bus_io.rx_data : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txv_q <= 1'b0;
      txd_q <= 8'h00;
    end else begin
      txv_q <= txv_d;
      txd_q <= txd_d;
    end
  end
`endif

  always_comb begin
    bus_io.rx_ready  = !arm_i && (state_q != StWr) && echo_ok;
    bus_io.mem_we    = (state_q == StWr);
    bus_io.mem_addr  = ptr_q;
    bus_io.mem_wdata = (state_q == StWr) ? acc_q : '0;
`ifdef HEXLOAD_ECHO_EN
    bus_io.tx_valid  = txv_q;
    bus_io.tx_data   = txd_q;
`else
    bus_io.tx_valid  = 1'b0;
    bus_io.tx_data   = 8'h00;
`endif
  end

  assign word_count_o   = wc_q;
  assign load_done_o    = done_q;
  assign err_bad_char_o = bad_q;
  assign err_overflow_o = ovf_q;

endmodule

// File: tb/tb_uart_hex_loader.sv
// Scoreboard bench for uart_hex_loader: a byte-level parsing model predicts memory
// writes, echoes and status; a negedge monitor checks writes and echoes as they appear.
module tb_uart_hex_loader;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DIGITS = DATA_W / 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              arm = 1'b0;
  logic [ADDR_W:0]   word_count;
  logic              load_done, err_bad, err_ovf;

  uart_hex_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  uart_hex_loader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .arm_i          (arm),
    .bus_io         (bus),
    .word_count_o   (word_count),
    .load_done_o    (load_done),
    .err_bad_char_o (err_bad),
    .err_overflow_o (err_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  bit rand_txr = 1'b0;

  logic [ADDR_W+DATA_W-1:0] exp_wr_q[$];
  logic [7:0]               exp_tx_q[$];

  // Reference model state: words written, digits pending, flags.
  logic [DATA_W-1:0] m_acc;
  int                m_cnt, m_wc;
  bit                m_done, m_bad, m_ovf;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = '0; m_cnt = 0; m_wc = 0; m_done = 0; m_bad = 0; m_ovf = 0;
  endtask

  function automatic int hex_val(input logic [7:0] b);
    if (b >= 8'h30 && b <= 8'h39) return int'(b) - 48;
    if (b >= 8'h41 && b <= 8'h46) return int'(b) - 65 + 10;
    if (b >= 8'h61 && b <= 8'h66) return int'(b) - 97 + 10;
    return -1;
  endfunction

  task automatic model_flush();
    exp_wr_q.push_back({ADDR_W'(m_wc), m_acc});
    m_wc++;
    m_acc = '0;
    m_cnt = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int v;
    if (m_done) return;
`ifdef HEXLOAD_ECHO_EN
    exp_tx_q.push_back(b);
`endif
    v = hex_val(b);
    if (v >= 0) begin
      if (m_wc == DEPTH) begin
        m_ovf = 1;
      end else begin
        m_acc = m_acc * 16 + DATA_W'(v);
        m_cnt++;
        if (m_cnt == DIGITS) model_flush();
      end
    end else if (b == 8'h20 || b == 8'h0D || b == 8'h0A || b == 8'h5F) begin
      if (m_cnt > 0) model_flush();
    end else if (b == 8'h2E) begin
      if (m_cnt > 0) model_flush();
      m_done = 1;
    end else if (m_wc != DEPTH) begin
      m_bad = 1; m_acc = '0; m_cnt = 0;
    end else begin
      m_bad = 1;
    end
  endtask

  // Present a byte, wait (bounded) for rx_ready, let it transfer on the next posedge.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    forever begin
      if (rand_txr) bus.tx_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.rx_ready) break;
      waited++;
      if (waited > 50) begin
        n_checks++; n_fail++;
        $display("FAIL rx_ready_timeout: byte 0x%0h not accepted, expected acceptance", b);
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        return;
      end
      @(negedge clk);
    end
    model_byte(b);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic check_status(input string tag);
    repeat (4) @(negedge clk);
    check({tag, "_word_count"}, 64'(word_count), 64'(m_wc));
    check({tag, "_load_done"},  64'(load_done), 64'(m_done));
    check({tag, "_err_bad"},    64'(err_bad), 64'(m_bad));
    check({tag, "_err_ovf"},    64'(err_ovf), 64'(m_ovf));
    check({tag, "_writes_seen"}, 64'(exp_wr_q.size()), 64'd0);
    check({tag, "_echoes_seen"}, 64'(exp_tx_q.size()), 64'd0);
    exp_wr_q.delete();
    exp_tx_q.delete();
  endtask

  task automatic do_arm(input bit with_byte);
    @(negedge clk);
    arm = 1'b1;
    bus.rx_valid = with_byte;
    bus.rx_data  = 8'h35;
    #1;
    check("rx_ready_under_arm", 64'(bus.rx_ready), 64'd0);
    @(posedge clk);
    #1;
    arm = 1'b0;
    bus.rx_valid = 1'b0;
    model_reset();
  endtask

  // Monitor: every memory write and echo strobe is matched against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.mem_we) begin
        if (exp_wr_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                   bus.mem_addr, bus.mem_wdata);
        end else begin
          check("mem_write", 64'({bus.mem_addr, bus.mem_wdata}), 64'(exp_wr_q.pop_front()));
        end
      end
      if (rst_n && bus.tx_valid) begin
        if (exp_tx_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_echo: byte 0x%0h, expected no echo", bus.tx_data);
        end else begin
          check("echo_byte", 64'(bus.tx_data), 64'(exp_tx_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  string hexc = "0123456789abcdefABCDEF";
  string sepc = " \r\n_";
  string badc = "Gz#@g:";

  initial begin
    logic [7:0] b;
    int n, k;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b1;
    model_reset();

    repeat (3) @(negedge clk);
    check("reset_word_count", 64'(word_count), 64'd0);
    check("reset_load_done", 64'(load_done), 64'd0);
    check("reset_flags", 64'({err_bad, err_ovf}), 64'd0);
    check("reset_mem_we", 64'(bus.mem_we), 64'd0);
    check("reset_tx_valid", 64'(bus.tx_valid), 64'd0);
    rst_n = 1'b1;

    rand_txr = 1'b1;
    send_str("DEADbeef\n");
    check_status("full_word");

    do_arm(1'b0);
    send_str("12 ");
    check_status("sep_flush");
    send_str(".");
    check_status("term_after_sep");

    do_arm(1'b0);
    send_str("1234");
    send_byte(8'h2E);
    @(negedge clk);
    check("flush_we", 64'(bus.mem_we), 64'd1);
    check("done_during_flush", 64'(load_done), 64'd0);
    @(negedge clk);
    check("done_after_flush", 64'(load_done), 64'd1);
    check_status("term_flush");

    do_arm(1'b0);
    for (int w = 0; w < DEPTH; w++) begin
      for (int d = 0; d < DIGITS; d++) send_byte(hexc[$urandom_range(0, 21)]);
    end
    send_str("7");
    check_status("overflow");

    do_arm(1'b0);
    send_str("12G34\n");
    check_status("bad_char");

    // tx_ready stall, then arm racing a valid byte.
    rand_txr = 1'b0;
    do_arm(1'b0);
    @(negedge clk);
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h35;
`ifdef HEXLOAD_ECHO_EN
    for (int i = 0; i < 5; i++) begin
      #1;
      check("rx_ready_stalled", 64'(bus.rx_ready), 64'd0);
      @(negedge clk);
    end
    bus.tx_ready = 1'b1;
`endif
    #1;
    check("rx_ready_released", 64'(bus.rx_ready), 64'd1);
    model_byte(8'h35);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    send_str("\n");
    check_status("stall");
    do_arm(1'b1);
    send_str("abc_");
    check_status("arm_race");

    // Reset in the middle of a word discards it.
    send_str("12");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    exp_tx_q.delete();
    send_str("9\n");
    check_status("mid_word_reset");

    // Random streams mixing digits, separators, bad bytes and terminators.
    rand_txr = 1'b1;
    for (int r = 0; r < 6; r++) begin
      do_arm(1'b0);
      n = (r % 2 == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(120, 170));
      for (int i = 0; i < n; i++) begin
        k = $urandom_range(0, 99);
        if (k < 75)      b = hexc[$urandom_range(0, 21)];
        else if (k < 92) b = sepc[$urandom_range(0, 3)];
        else if (k < 98) b = badc[$urandom_range(0, 5)];
        else             b = 8'h2E;
        send_byte(b);
      end
      send_str(".3\n");
      check_status("random");
    end

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_hex_loader.md
# uart_hex_loader

Parametrised ASCII-hex program loader sitting between the UART receiver/transmitter and the CPU instruction memory. It turns a byte stream of hex digits into DATA_W-bit words and writes them sequentially into a DEPTH-entry memory. It optionally echoes each accepted byte. This generation adds case-insensitive hex, separator and terminator framing, partial-word flush, an overflow/bad-character error report and a load-done handshake for releasing the CPU.

## Interface
- DATA_W, 32, word width in bits; must be a multiple of 4, at least 8. DIGITS = DATA_W/4.
- DEPTH, 16, number of memory words; at least 2.
- ADDR_W, $clog2(DEPTH), memory address width.
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- arm  in  1  single-cycle pulse: restart a load from address 0
- rx_valid  in  1  received byte available
- rx_data  in  8  received byte
- rx_ready  out  1  byte consumed this cycle (valid/ready handshake)
- tx_ready  in  1  transmitter can take a byte (!tx_busy)
- tx_valid  out  1  echo byte strobe
- tx_data  out  8  echo byte
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  DATA_W  write data
- word_count  out  ADDR_W+1  words written since arm/reset
- load_done  out  1  level; high once the terminator has been processed
- err_bad_char  out  1  sticky; a non-hex, non-separator byte was seen
- err_overflow  out  1  sticky; a digit arrived with the memory full

## Operation
- States: S_ACC (accumulating), S_WR (write cycle), S_FULL (memory full), S_DONE.
- Reset and arm: state S_ACC, accumulator 0, digit count 0, write pointer 0, all outputs 0.
- Byte transfer: occurs on a cycle with rx_valid && rx_ready. rx_ready = !arm && state in {S_ACC, S_FULL, S_DONE} && (tx_ready, when echo is enabled). rx_ready is combinational.
- Byte classes:
  - Digit: '0'-'9', 'A'-'F', 'a'-'f'.
  - Separator: 0x20, 0x0D, 0x0A, '_'.
  - Terminator: '.' (0x2E).
  - Anything else: bad.
- Digit in S_ACC:
  - acc <= {acc[DATA_W-5:0], nib}, and cnt increments.
  - When cnt reaches DIGITS, go to S_WR with the full word.
- Separator with 0 < cnt < DIGITS: flush the partial word, right-justified and zero-extended, then go to S_WR. A separator with cnt = 0 is ignored.
- Terminator: flush the partial word if cnt > 0, then go to S_DONE and set load_done. With cnt = 0, go directly to S_DONE.
- Bad byte: set err_bad_char, discard the partial accumulator (cnt <= 0), stay in the current state.
- S_WR (one cycle): mem_we = 1, mem_addr = pointer, mem_wdata = word. Then the pointer and word_count increment, acc/cnt clear, and the next state is S_ACC, or S_FULL if word_count reaches DEPTH, or S_DONE if the write was a terminator flush.
- S_FULL: a digit sets err_overflow and is dropped. A terminator goes to S_DONE. Separators are ignored.
- S_DONE: bytes are accepted and dropped, with no echo and no flag changes. The only exits are arm and reset.
- Pointer never wraps: maximum address DEPTH-1, word_count saturates at DEPTH.

## Timing
- Write latency: mem_we rises exactly one cycle after the transfer of the completing digit, separator or terminator. rx_ready is low during S_WR.
- Echo: tx_valid is high for one cycle, the cycle after each transfer in S_ACC or S_FULL. tx_data equals the byte.
- load_done rises in the cycle after the terminator transfer, or after the flush write. It stays high until arm or reset.
- arm wins over a simultaneous rx_valid; that byte is not consumed.
- Reset mid-word or mid-write: partial data is discarded and no mem_we is issued after reset.
- Error flags are sticky until arm or reset.

## Configuration
- HEXLOAD_ECHO_EN defined: echo path present, and rx_ready is gated by tx_ready.
- HEXLOAD_ECHO_EN undefined:
  - tx_valid is tied 0 and tx_data is tied 0.
  - rx_ready ignores tx_ready.
  - All other behaviour is unchanged.

## Structure
- hexload_pkg holds:
  - state enum;
  - ASCII constants (separators, terminator);
  - function ascii_to_nibble returning {is_digit, nib}.
- Sub-module hex_classify: combinational byte to {is_digit, is_sep, is_term, is_bad, nib}. The FSM, accumulator and pointer live in uart_hex_loader.

## Test plan
- DATA_W=32, DEPTH=16, echo on: "DEADbeef\n" → one mem_we at addr 0, wdata 0xDEADBEEF. word_count=1. Eight tx_valid strobes carrying "DEADbeef", and the '\n' echoed.
- "12 " → write addr 0 wdata 0x00000012. Then "." → load_done=1 with no extra write.
- "1234." → flush write of 0x00001234, then load_done is high the cycle after the write.
- 16 full words, then digit '7' → err_overflow=1, no 17th mem_we, word_count=16.
- "12G34\n" → err_bad_char=1, single write of 0x00000034.
- tx_ready held low for 5 cycles with rx_valid high → rx_ready low throughout, byte consumed on the first cycle tx_ready=1. Also assert arm while rx_valid=1 → byte not consumed and the pointer returns to 0.
